// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for the CPU memory arbiter: machine word and arbiter FSM states.
package cpu_mem_arbiter_pkg;

   typedef logic [15:0] lc3b_word;

   localparam int WORD_WIDTH = $bits(lc3b_word);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      DONE   = 2'd3
   } lc3b_arb_state;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Serialises instruction-fetch and data ports onto one non-pipelined memory port.
// Define CPU_ARB_RR_EN for round-robin on simultaneous requests; otherwise data wins.
module cpu_mem_arbiter
   import cpu_mem_arbiter_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req,
   input  logic [WIDTH-1:0] i_addr,
   output logic [WIDTH-1:0] i_rdata,
   output logic             i_resp,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   input  logic [1:0]       d_mbe,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_resp,
   output logic             mem_read,
   output logic             mem_write,
   output logic [WIDTH-1:0] mem_address,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [1:0]       mem_byte_enable,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_resp
);

   lc3b_arb_state    state_reg, state_next;
   logic [WIDTH-1:0] addr_reg, wdata_reg, i_rdata_reg, d_rdata_reg;
   logic [1:0]       mbe_reg;
   logic             we_reg, served_d_reg, keep_reg;
   logic             grant_i, grant_d;
`ifdef CPU_ARB_RR_EN
   logic             last_grant_reg;   // 1 = data served last
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         mbe_reg      <= 2'b00;
         we_reg       <= 1'b0;
         served_d_reg <= 1'b0;
         keep_reg     <= 1'b0;
         i_rdata_reg  <= '0;
         d_rdata_reg  <= '0;
`ifdef CPU_ARB_RR_EN
         last_grant_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (grant_d) begin
                  addr_reg     <= d_addr;
                  wdata_reg    <= d_wdata;
                  we_reg       <= d_we;
                  mbe_reg      <= d_we ? d_mbe : 2'b11;
                  served_d_reg <= 1'b1;
                  keep_reg     <= 1'b1;
               end else if (grant_i) begin
                  addr_reg     <= i_addr;
                  we_reg       <= 1'b0;
                  mbe_reg      <= 2'b11;
                  served_d_reg <= 1'b0;
                  keep_reg     <= 1'b1;
               end
`ifdef CPU_ARB_RR_EN
               if (grant_d || grant_i)
                  last_grant_reg <= grant_d;
`endif
            end
            // A dropped request (pipeline flush) only suppresses the response pulse
            I_BUSY: begin
               if (!i_req)
                  keep_reg <= 1'b0;
               if (mem_resp)
                  i_rdata_reg <= mem_rdata;
            end
            D_BUSY: begin
               if (!d_req)
                  keep_reg <= 1'b0;
               if (mem_resp && !we_reg)
                  d_rdata_reg <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next      = state_reg;
      grant_i         = 1'b0;
      grant_d         = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = addr_reg;
      mem_wdata       = wdata_reg;
      mem_byte_enable = mbe_reg;
      i_resp          = 1'b0;
      d_resp          = 1'b0;
      i_rdata         = i_rdata_reg;
      d_rdata         = d_rdata_reg;

      case (state_reg)
         IDLE: begin
`ifdef CPU_ARB_RR_EN
            if (d_req && i_req) begin
               grant_d = ~last_grant_reg;
               grant_i = last_grant_reg;
            end else begin
               grant_d = d_req;
               grant_i = i_req;
            end
`else
            grant_d = d_req;
            grant_i = i_req & ~d_req;
`endif
            if (grant_d)
               state_next = D_BUSY;
            else if (grant_i)
               state_next = I_BUSY;
         end
         I_BUSY: begin
            mem_read = 1'b1;
            if (mem_resp)
               state_next = DONE;
         end
         D_BUSY: begin
            mem_read  = ~we_reg;
            mem_write = we_reg;
            if (mem_resp)
               state_next = DONE;
         end
         DONE: begin
            i_resp     = keep_reg & ~served_d_reg;
            d_resp     = keep_reg & served_d_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
